// File: rtl/uart_read_pkg.sv
// Shared types and constants for the UART-to-register read sequencer.
package uart_read_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned WORD_BYTES   = 4;
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StWrite = 2'd2
    } state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// RX byte FIFO: one push per cycle, pop of 1 or WORD_BYTES entries per cycle,
// with a little-endian peek of the oldest WORD_BYTES entries.
module uart_byte_fifo
    import uart_read_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [BYTE_W-1:0]            push_data,
    input  logic                         pop,
    input  logic                         pop_word,
    output logic                         full,
    output logic [CntW-1:0]              count,
    output logic [WORD_BYTES*BYTE_W-1:0] peek
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_byte_fifo: DEPTH must be a power of 2 and at least 4");
    end

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   pop_n;
    logic              push_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_n   = pop ? (pop_word ? CntW'(WORD_BYTES) : CntW'(1)) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            // Power-of-2 depth: pointer arithmetic wraps naturally.
            rd_ptr_q <= rd_ptr_q + PtrW'(pop_n);
            count_q  <= count_q + CntW'(push_ok) - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            peek[i*BYTE_W +: BYTE_W] = mem[rd_ptr_q + PtrW'(i)];
        end
    end

endmodule

// File: rtl/uart_read_sequencer.sv
// Stalls the core on a UARTtoReg instruction until enough RX bytes are buffered,
// then writes the assembled value to the register file. Optional UART_READ_TIMEOUT_EN.
module uart_read_sequencer
    import uart_read_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        req,
    input  logic        req_word,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        wr_en,
    output logic [4:0]  wr_rd,
    output logic [31:0] wr_data,
    output logic        timeout
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("uart_read_sequencer: TIMEOUT_CYCLES must be nonzero");
    end

    state_e            state_q;
    logic              word_q;
    logic [4:0]        rd_q;
    logic              wr_en_q;
    logic [31:0]       wr_data_q;
    logic              fifo_full;
    logic [CntW-1:0]   fifo_count;
    logic [31:0]       fifo_peek;
    logic [CntW-1:0]   need;
    logic              push;
    logic              have_data;
    logic              tmo_hit;
    logic [31:0]       read_data;

    // Outputs are gated by reset so they read zero while reset is held.
    assign rx_ready  = reset && !fifo_full;
    assign push      = rx_valid && rx_ready;
    assign stall     = reset && (((state_q == StIdle) && req) || (state_q == StWait));
    assign need      = word_q ? CntW'(WORD_BYTES) : CntW'(1);
    assign have_data = (state_q == StWait) && (fifo_count >= need);
    assign read_data = word_q ? fifo_peek : {{(32 - BYTE_W){1'b0}}, fifo_peek[BYTE_W-1:0]};
    assign wr_en     = wr_en_q;
    assign wr_rd     = rd_q;
    assign wr_data   = wr_data_q;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_data),
        .pop       (have_data),
        .pop_word  (word_q),
        .full      (fifo_full),
        .count     (fifo_count),
        .peek      (fifo_peek)
    );

`ifdef UART_READ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TmoW-1:0] tmo_q;
    logic            timeout_q;

    // Arriving data wins over an expiring timer in the same cycle.
    assign tmo_hit = (state_q == StWait) && !have_data && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if ((state_q == StWait) && !have_data && !tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            word_q    <= 1'b0;
            rd_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
`ifdef UART_READ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
`ifdef UART_READ_TIMEOUT_EN
            timeout_q <= tmo_hit;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        word_q  <= req_word;
                        rd_q    <= req_rd;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (have_data) begin
                        wr_data_q <= read_data;
                        wr_en_q   <= 1'b1;
                        state_q   <= StWrite;
                    end else if (tmo_hit) begin
                        wr_data_q <= TIMEOUT_DATA;
                        wr_en_q   <= 1'b1;
                        state_q   <= StWrite;
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_read_sequencer.sv
// Self-checking bench for uart_read_sequencer: directed scenarios plus random
// traffic checked every cycle against a byte-queue transaction model.
module tb_uart_read_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        req;
    logic        req_word;
    logic [4:0]  req_rd;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        timeout;

    always #5 clk = ~clk;

    uart_read_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .req      (req),
        .req_word (req_word),
        .req_rd   (req_rd),
        .stall    (stall),
        .wr_en    (wr_en),
        .wr_rd    (wr_rd),
        .wr_data  (wr_data),
        .timeout  (timeout)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: buffered bytes plus one outstanding read transaction.
    logic [7:0]  bq[$];
    bit          m_busy = 0;
    bit          m_wr   = 0;
    bit          m_tmo  = 0;
    int          m_need = 1;
    int          m_wait = 0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    int          stall_cnt;
    bit          saw_wr;
    bit          saw_tmo;
    logic [31:0] last_data;
    logic [4:0]  last_rd;
    int          last_wr_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic w,
                         input logic [4:0] rd);
        bit acc;
        bit nxt_wr;
        rx_valid = v;
        rx_data  = d;
        req      = r;
        req_word = w;
        req_rd   = rd;
        @(negedge clk);
        chk("rx_ready", 32'(rx_ready), 32'(bq.size() < DEPTH));
        chk("stall", 32'(stall), 32'(m_busy || (!m_wr && r)));
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        chk("timeout", 32'(timeout), 32'(m_wr && m_tmo));
        if (m_wr) begin
            chk("wr_data", wr_data, m_data);
            chk("wr_rd", 32'(wr_rd), 32'(m_rd));
        end
        if (stall) stall_cnt++;
        if (timeout) saw_tmo = 1;
        if (wr_en) begin
            saw_wr      = 1;
            last_data   = wr_data;
            last_rd     = wr_rd;
            last_wr_cyc = cyc;
        end
        // Advance the model across the coming rising edge.
        acc    = v && (bq.size() < DEPTH);
        nxt_wr = 0;
        if (m_busy) begin
            if (bq.size() >= m_need) begin
                m_data = '0;
                for (int i = 0; i < m_need; i++) begin
                    m_data = m_data | (32'(bq.pop_front()) << (8 * i));
                end
                m_tmo  = 0;
                nxt_wr = 1;
                m_busy = 0;
            end else begin
                m_wait++;
`ifdef UART_READ_TIMEOUT_EN
                if (m_wait == TMO) begin
                    m_data = 32'hFFFF_FFFF;
                    m_tmo  = 1;
                    nxt_wr = 1;
                    m_busy = 0;
                end
`endif
            end
        end else if (!m_wr && r) begin
            m_busy = 1;
            m_need = w ? 4 : 1;
            m_rd   = rd;
            m_wait = 0;
        end
        if (acc) bq.push_back(d);
        m_wr = nxt_wr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0, 5'd0);
    endtask

    // Holds req until the write cycle is seen; feed_at schedules one RX byte.
    task automatic do_read(input logic w, input logic [4:0] rd, input int feed_at,
                           input logic [7:0] feed_byte, input bit rnd, output int lat);
        int         k;
        int         start;
        logic       v;
        logic [7:0] d;
        k         = 0;
        start     = cyc;
        saw_wr    = 0;
        saw_tmo   = 0;
        stall_cnt = 0;
        while (!saw_wr && k < 300) begin
            v = (k == feed_at);
            d = feed_byte;
            if (rnd) begin
                v = 1'($urandom_range(0, 1));
                d = 8'($urandom);
            end
            cycle(v, d, 1'b1, w, rd);
            k++;
        end
        chk("read_done", 32'(saw_wr), 32'd1);
        lat = last_wr_cyc - start;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = 1'b1;
        req_word = 1'b1;
        req_rd   = 5'd7;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_rd", 32'(wr_rd), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
        bq.delete();
        m_busy   = 0;
        m_wr     = 0;
        m_tmo    = 0;
        reset    = 1'b1;
        req      = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, count %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        req      = 1'b0;
        req_word = 1'b0;
        req_rd   = '0;
        do_reset();

        // Word read with four bytes already buffered.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        do_read(1'b1, 5'd5, -1, 8'h00, 0, lat);
        chk("s1_latency", 32'(lat), 32'd2);
        chk("s1_data", last_data, 32'h4433_2211);
        chk("s1_rd", 32'(last_rd), 32'd5);
        chk("s1_stall_cycles", 32'(stall_cnt), 32'd2);

        // Byte read from an empty FIFO, byte arrives 10 cycles later.
        do_read(1'b0, 5'd3, 10, 8'hA5, 0, lat);
        chk("s2_latency", 32'(lat), 32'd12);
        chk("s2_stall_cycles", 32'(stall_cnt), 32'd12);
        chk("s2_data", last_data, 32'h0000_00A5);
        chk("s2_rd", 32'(last_rd), 32'd3);

        // Fill the FIFO, offer a ninth byte, then drain with two word reads.
        for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
        push_byte(8'hEE);
        push_byte(8'hEF);
        chk("s3_full_ready", 32'(rx_ready), 32'd0);
        chk("s3_full_count", 32'(dut.u_fifo.count), 32'd8);
        do_read(1'b1, 5'd9, -1, 8'h00, 0, lat);
        chk("s3_first_word", last_data, 32'h8382_8180);
        do_read(1'b1, 5'd10, -1, 8'h00, 0, lat);
        chk("s3_second_word", last_data, 32'h8786_8584);
        chk("s3_drained_count", 32'(dut.u_fifo.count), 32'd0);

        // Push in the same cycle as a 4-byte pop.
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        do_read(1'b1, 5'd11, 1, 8'hC7, 0, lat);
        chk("s4_word", last_data, 32'h0403_0201);
        chk("s4_count_after", 32'(dut.u_fifo.count), 32'd1);
        do_read(1'b0, 5'd12, -1, 8'h00, 0, lat);
        chk("s4_pushed_byte", last_data, 32'h0000_00C7);
        chk("s4_byte_latency", 32'(lat), 32'd2);

        // Reset while waiting for data, then a clean read.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 5'd13);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 5'd13);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 5'd13);
        do_reset();
        do_read(1'b0, 5'd14, 2, 8'h3C, 0, lat);
        chk("s5_data", last_data, 32'h0000_003C);
        chk("s5_rd", 32'(last_rd), 32'd14);
        chk("s5_latency", 32'(lat), 32'd4);

`ifdef UART_READ_TIMEOUT_EN
        // Word read that can never be satisfied: two bytes stay buffered.
        push_byte(8'hAA);
        push_byte(8'hBB);
        do_read(1'b1, 5'd15, -1, 8'h00, 0, lat);
        chk("s6_latency", 32'(lat), 32'd17);
        chk("s6_data", last_data, 32'hFFFF_FFFF);
        chk("s6_pulse", 32'(saw_tmo), 32'd1);
        chk("s6_count", 32'(dut.u_fifo.count), 32'd2);
`endif

        // Random traffic with back-to-back reads.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = int'($urandom_range(0, 5));
            for (int j = 0; j < n; j++) begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0, 5'd0);
            end
            do_read(1'($urandom_range(0, 1)), 5'($urandom), -1, 8'h00, 1, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
